// File: rtl/traffic_pkg.sv
// rtl/traffic_pkg.sv - shared interval-state enum, prog_sel codes and duration helper
package traffic_pkg;

  typedef enum logic [1:0] {
    ST_GREEN  = 2'd0,
    ST_YELLOW = 2'd1,
    ST_ALLRED = 2'd2,
    ST_WALK   = 2'd3
  } ival_state_e;

  localparam logic [1:0] SEL_GREEN  = 2'd0;
  localparam logic [1:0] SEL_YELLOW = 2'd1;
  localparam logic [1:0] SEL_ALLRED = 2'd2;
  localparam logic [1:0] SEL_WALK   = 2'd3;

  localparam int DUR_W = 16;

  // A programmed zero still has to occupy one tick, otherwise the timer would stall.
  function automatic logic [DUR_W-1:0] eff_ticks(input logic [DUR_W-1:0] v);
    return (v == '0) ? DUR_W'(1) : v;
  endfunction

endpackage

// File: rtl/traffic_tick_gen.sv
// rtl/traffic_tick_gen.sv - free-running prescaler, one-cycle tick every TICK_DIV clocks
module traffic_tick_gen #(
  parameter int TICK_DIV = 50_000_000
) (
  input  logic clk_i,
  input  logic rst_ni,
  output logic tick_o
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_q;

  assign tick_o = (cnt_q == LAST);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (tick_o) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/traffic_phase_ctrl.sv
// rtl/traffic_phase_ctrl.sv - N-phase intersection controller: FSM, interval timer, program regs, lamps
// Optional DEMAND_SKIP_EN: approaches without latched vehicle demand are skipped (phase 0 always served).
module traffic_phase_ctrl
  import traffic_pkg::*;
#(
  parameter int NUM_PHASES = 2,
  parameter int TW         = 4,
  parameter int TICK_DIV   = 50_000_000,
  parameter int DEF_GREEN  = 6,
  parameter int DEF_YELLOW = 2,
  parameter int DEF_ALLRED = 1,
  parameter int DEF_WALK   = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_PHASES-1:0]         sensor,
  input  logic                          walk_req,
  input  logic                          prog_en,
  input  logic [1:0]                    prog_sel,
  input  logic [$clog2(NUM_PHASES)-1:0] prog_phase,
  input  logic [TW-1:0]                 prog_val,
  output logic [NUM_PHASES-1:0]         lamp_g,
  output logic [NUM_PHASES-1:0]         lamp_y,
  output logic [NUM_PHASES-1:0]         lamp_r,
  output logic                          walk,
  output logic                          walk_pending,
  output logic [$clog2(NUM_PHASES)-1:0] phase,
  output logic [TW-1:0]                 count_down
);

  localparam int PW = $clog2(NUM_PHASES);
  localparam logic [NUM_PHASES-1:0] LAMP0 = NUM_PHASES'(1);

  function automatic logic [TW-1:0] dur(input logic [TW-1:0] v);
    return TW'(eff_ticks(DUR_W'(v)));
  endfunction

  logic tick;

  ival_state_e           state_q, state_d;
  logic [PW-1:0]         phase_q, phase_d, nxt_phase;
  logic [TW-1:0]         count_q, count_d;
  logic [NUM_PHASES-1:0] lamp_g_q, lamp_g_d;
  logic [NUM_PHASES-1:0] lamp_y_q, lamp_y_d;
  logic [NUM_PHASES-1:0] lamp_r_q, lamp_r_d;
  logic                  walk_q, walk_d;
  logic                  pend_q, pend_d;
  logic                  enter_walk, enter_green;

  logic [TW-1:0] green_q [NUM_PHASES];
  logic [TW-1:0] yellow_q, allred_q, walkt_q;

  traffic_tick_gen #(
    .TICK_DIV(TICK_DIV)
  ) u_tick (
    .clk_i (clk),
    .rst_ni(reset),
    .tick_o(tick)
  );

`ifdef DEMAND_SKIP_EN
  logic [NUM_PHASES-1:0] demand_q, demand_d;

  // Lowest index above the current phase with demand; falling through lands on phase 0.
  always_comb begin
    nxt_phase = '0;
    for (int k = NUM_PHASES - 1; k >= 1; k--) begin
      if (PW'(k) > phase_q && demand_q[k]) begin
        nxt_phase = PW'(k);
      end
    end
  end

  always_comb begin
    demand_d = demand_q | sensor;
    for (int i = 0; i < NUM_PHASES; i++) begin
      if (enter_green && phase_d == PW'(i)) begin
        demand_d[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      demand_q <= '0;
    end else begin
      demand_q <= demand_d;
    end
  end
`else
  logic unused_sensor;
  assign unused_sensor = ^sensor;

  always_comb begin
    nxt_phase = (phase_q == PW'(NUM_PHASES - 1)) ? '0 : phase_q + 1'b1;
  end
`endif

  // Interval loads read the *_q program registers, so a coincident write only affects later loads.
  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    count_d = count_q;
    if (tick) begin
      if (count_q > TW'(1)) begin
        count_d = count_q - 1'b1;
      end else begin
        unique case (state_q)
          ST_GREEN: begin
            state_d = ST_YELLOW;
            count_d = dur(yellow_q);
          end
          ST_YELLOW: begin
            state_d = ST_ALLRED;
            count_d = dur(allred_q);
          end
          ST_ALLRED, ST_WALK: begin
            if (state_q == ST_ALLRED && pend_q) begin
              state_d = ST_WALK;
              count_d = dur(walkt_q);
            end else begin
              state_d = ST_GREEN;
              phase_d = nxt_phase;
              count_d = dur(green_q[nxt_phase]);
            end
          end
        endcase
      end
    end
  end

  always_comb begin
    enter_walk  = (state_d == ST_WALK) && (state_q != ST_WALK);
    enter_green = (state_d == ST_GREEN) && (state_q != ST_GREEN);
    pend_d      = enter_walk ? 1'b0 : (pend_q | walk_req);
    walk_d      = (state_d == ST_WALK);
    lamp_g_d    = '0;
    lamp_y_d    = '0;
    lamp_r_d    = '0;
    for (int i = 0; i < NUM_PHASES; i++) begin
      lamp_g_d[i] = (state_d == ST_GREEN)  && (phase_d == PW'(i));
      lamp_y_d[i] = (state_d == ST_YELLOW) && (phase_d == PW'(i));
      lamp_r_d[i] = !(lamp_g_d[i] || lamp_y_d[i]);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_GREEN;
      phase_q  <= '0;
      count_q  <= dur(TW'(DEF_GREEN));
      lamp_g_q <= LAMP0;
      lamp_y_q <= '0;
      lamp_r_q <= ~LAMP0;
      walk_q   <= 1'b0;
      pend_q   <= 1'b0;
      for (int i = 0; i < NUM_PHASES; i++) begin
        green_q[i] <= TW'(DEF_GREEN);
      end
      yellow_q <= TW'(DEF_YELLOW);
      allred_q <= TW'(DEF_ALLRED);
      walkt_q  <= TW'(DEF_WALK);
    end else begin
      state_q  <= state_d;
      phase_q  <= phase_d;
      count_q  <= count_d;
      lamp_g_q <= lamp_g_d;
      lamp_y_q <= lamp_y_d;
      lamp_r_q <= lamp_r_d;
      walk_q   <= walk_d;
      pend_q   <= pend_d;
      if (prog_en) begin
        case (prog_sel)
          SEL_GREEN: begin
            if ({1'b0, prog_phase} < (PW + 1)'(NUM_PHASES)) begin
              green_q[prog_phase] <= prog_val;
            end
          end
          SEL_YELLOW: yellow_q <= prog_val;
          SEL_ALLRED: allred_q <= prog_val;
          default:    walkt_q  <= prog_val;
        endcase
      end
    end
  end

  assign lamp_g       = lamp_g_q;
  assign lamp_y       = lamp_y_q;
  assign lamp_r       = lamp_r_q;
  assign walk         = walk_q;
  assign walk_pending = pend_q;
  assign phase        = phase_q;
  assign count_down   = count_q;

endmodule
